// File: rtl/expr_pkg.sv
// Shared definitions for the streaming expression evaluator.
//   - ASCII constants for the characters the grammar accepts
//   - one-hot parser state encoding
//   - character-class enum produced by the classifier
package expr_pkg;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_STAR  = 8'h2A;

    typedef enum logic [2:0] {
        S_DIGIT = 3'b001,   // expecting a digit
        S_OP    = 3'b010,   // expecting an operator
        S_ERR   = 3'b100    // absorbing syntax-error state
    } state_e;

    typedef enum logic [1:0] {
        CC_DIGIT  = 2'd0,
        CC_ADDSUB = 2'd1,
        CC_MUL    = 2'd2,
        CC_BAD    = 2'd3
    } char_class_e;

endpackage

// File: rtl/expr_char_class.sv
// Combinational character classifier.
// Ports:
//   ch_i     in  8  ASCII character
//   cls_o    out    class of the character (digit, +/-, *, anything else)
//   digit_o  out 4  numeric value when the character is a digit, else 0
module expr_char_class
    import expr_pkg::*;
(
    input  logic [7:0]  ch_i,
    output char_class_e cls_o,
    output logic [3:0]  digit_o
);

    always_comb begin
        cls_o   = CC_BAD;
        digit_o = 4'd0;
        if (ch_i >= CH_0 && ch_i <= CH_9) begin
            cls_o   = CC_DIGIT;
            // '0'..'9' are 0x30..0x39, so the low nibble is the value
            digit_o = ch_i[3:0];
        end else if (ch_i == CH_PLUS || ch_i == CH_MINUS) begin
            cls_o = CC_ADDSUB;
        end else if (ch_i == CH_STAR) begin
            cls_o = CC_MUL;
        end
    end

endmodule

// File: rtl/expr_eval.sv
// Streaming evaluator for single-digit expressions: digit (op digit)*,
// op in {+,-,*}, '*' binding tighter than '+'/'-'. The running value is
// published after every accepted digit; all outputs are registered.
// Ports:
//   clk           in      clock, rising edge
//   clr           in      asynchronous active-high reset
//   in            in   8  ASCII character
//   in_valid      in      character on `in` is consumed this cycle
//   result        out  W  signed value of the expression so far (wraps)
//   result_valid  out     prefix so far is a complete legal expression
//   err           out     sticky syntax error, cleared only by clr
//   ops_seen      out  8  operators accepted, saturating at 255
module expr_eval
    import expr_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [7:0]          in,
    input  logic                in_valid,
    output logic signed [W-1:0] result,
    output logic                result_valid,
    output logic                err,
    output logic [7:0]          ops_seen
);

    char_class_e cls;
    logic [3:0]  digit;

    expr_char_class u_cc (
        .ch_i    (in),
        .cls_o   (cls),
        .digit_o (digit)
    );

    state_e state_q, state_d;

    // sum_q holds the completed additive terms; term_q is the product
    // currently being built, applied with sign_q (1 = subtract).
    logic signed [W-1:0] sum_q, sum_d;
    logic signed [W-1:0] term_q, term_d;
    logic                sign_q, sign_d;
    logic                mul_pend_q, mul_pend_d;
    logic signed [W-1:0] result_q, result_d;
    logic                rv_q, rv_d;
    logic                err_q, err_d;
    logic [7:0]          ops_q, ops_d;

    logic signed [W-1:0] digit_s;
    logic signed [W-1:0] product;
    logic signed [W-1:0] term_n;

    // Single W x 4 multiplier; the low W bits of the product are the
    // wrapped result regardless of signedness.
    assign digit_s = $signed({{(W-4){1'b0}}, digit});
    assign product = term_q * digit_s;
    assign term_n  = mul_pend_q ? product : digit_s;

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state_q <= S_DIGIT;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            case (state_q)
                S_DIGIT: state_d = (cls == CC_DIGIT) ? S_OP : S_ERR;
                S_OP:    state_d = (cls == CC_ADDSUB || cls == CC_MUL) ? S_DIGIT : S_ERR;
                default: state_d = S_ERR;
            endcase
        end
    end

    // Datapath / output next values
    always_comb begin
        sum_d      = sum_q;
        term_d     = term_q;
        sign_d     = sign_q;
        mul_pend_d = mul_pend_q;
        result_d   = result_q;
        rv_d       = rv_q;
        err_d      = err_q;
        ops_d      = ops_q;
        if (in_valid) begin
            case (state_q)
                S_DIGIT: begin
                    if (cls == CC_DIGIT) begin
                        result_d   = sign_q ? (sum_q - term_n) : (sum_q + term_n);
                        term_d     = term_n;
                        mul_pend_d = 1'b0;
                        rv_d       = 1'b1;
                    end else begin
                        err_d = 1'b1;
                        rv_d  = 1'b0;
                    end
                end
                S_OP: begin
                    if (cls == CC_ADDSUB) begin
                        // Fold the finished term into the sum, then start a new one
                        sum_d  = sign_q ? (sum_q - term_q) : (sum_q + term_q);
                        sign_d = (in == CH_MINUS);
                        term_d = '0;
                        rv_d   = 1'b0;
                        ops_d  = (ops_q == 8'hFF) ? ops_q : ops_q + 8'd1;
                    end else if (cls == CC_MUL) begin
                        mul_pend_d = 1'b1;
                        rv_d       = 1'b0;
                        ops_d      = (ops_q == 8'hFF) ? ops_q : ops_q + 8'd1;
                    end else begin
                        err_d = 1'b1;
                        rv_d  = 1'b0;
                    end
                end
                default: ;  // S_ERR absorbs everything until clr
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sum_q      <= '0;
            term_q     <= '0;
            sign_q     <= 1'b0;
            mul_pend_q <= 1'b0;
            result_q   <= '0;
            rv_q       <= 1'b0;
            err_q      <= 1'b0;
            ops_q      <= 8'd0;
        end else begin
            sum_q      <= sum_d;
            term_q     <= term_d;
            sign_q     <= sign_d;
            mul_pend_q <= mul_pend_d;
            result_q   <= result_d;
            rv_q       <= rv_d;
            err_q      <= err_d;
            ops_q      <= ops_d;
        end
    end

    assign result       = result_q;
    assign result_valid = rv_q;
    assign err          = err_q;
    assign ops_seen     = ops_q;

endmodule

// File: tb/tb_expr_eval.sv
// Directed bench for expr_eval. Inputs change on the falling edge; outputs
// are sampled on the following falling edge, after the rising edge that
// consumed the character. Observed outputs are packed as
// {result[15:0], result_valid, err, ops_seen[7:0]}.
module tb_expr_eval;

    logic        clk = 1'b0;
    logic        clr;
    logic [7:0]  in_ch;
    logic        in_valid;
    logic signed [15:0] result;
    logic        result_valid;
    logic        err;
    logic [7:0]  ops_seen;

    int n_cmp = 0;
    int n_bad = 0;

    wire [25:0] obs = {result, result_valid, err, ops_seen};

    expr_eval #(.W(16)) dut (
        .clk          (clk),
        .clr          (clr),
        .in           (in_ch),
        .in_valid     (in_valid),
        .result       (result),
        .result_valid (result_valid),
        .err          (err),
        .ops_seen     (ops_seen)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [7:0] c);
        in_ch    = c;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_ch    = 8'h00;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1; in_valid = 1'b0; in_ch = 8'h00;
        repeat (2) @(negedge clk);
        if (obs !== 26'd0) begin n_bad++; $display("FAIL reset_held: got %h want %h", obs, 26'd0); end
        n_cmp++;
        clr = 1'b0;
        @(negedge clk);
        if (obs !== 26'd0) begin n_bad++; $display("FAIL reset_release: got %h want %h", obs, 26'd0); end
        n_cmp++;
    endtask

    task automatic test_add();
        string s = "1+2";
        logic [25:0] exp [3] = '{ {16'd1,1'b1,1'b0,8'd0}, {16'd1,1'b0,1'b0,8'd1}, {16'd3,1'b1,1'b0,8'd1} };
        do_clr();
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            if (obs !== exp[i]) begin n_bad++; $display("FAIL add[%0d]: got %h want %h", i, obs, exp[i]); end
            n_cmp++;
        end
    endtask

    task automatic test_precedence();
        string s = "2+3*4";
        logic [25:0] exp [5] = '{ {16'd2,1'b1,1'b0,8'd0}, {16'd2,1'b0,1'b0,8'd1}, {16'd5,1'b1,1'b0,8'd1},
                                  {16'd5,1'b0,1'b0,8'd2}, {16'd14,1'b1,1'b0,8'd2} };
        do_clr();
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            if (obs !== exp[i]) begin n_bad++; $display("FAIL prec[%0d]: got %h want %h", i, obs, exp[i]); end
            n_cmp++;
        end
    endtask

    task automatic test_negative();
        string s = "9-8*7";
        logic [25:0] exp [5] = '{ {16'd9,1'b1,1'b0,8'd0}, {16'd9,1'b0,1'b0,8'd1}, {16'd1,1'b1,1'b0,8'd1},
                                  {16'd1,1'b0,1'b0,8'd2}, {16'hFFD1,1'b1,1'b0,8'd2} };
        do_clr();
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            if (obs !== exp[i]) begin n_bad++; $display("FAIL neg[%0d]: got %h want %h", i, obs, exp[i]); end
            n_cmp++;
        end
    endtask

    task automatic test_mixed();
        // 3*4 - 5*6 + 7 = 12 - 30 + 7 = -11
        string s = "3*4-5*6+7";
        logic [25:0] exp [9] = '{ {16'd3,1'b1,1'b0,8'd0}, {16'd3,1'b0,1'b0,8'd1}, {16'd12,1'b1,1'b0,8'd1},
                                  {16'd12,1'b0,1'b0,8'd2}, {16'd7,1'b1,1'b0,8'd2}, {16'd7,1'b0,1'b0,8'd3},
                                  {16'hFFEE,1'b1,1'b0,8'd3}, {16'hFFEE,1'b0,1'b0,8'd4}, {16'hFFF5,1'b1,1'b0,8'd4} };
        do_clr();
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            if (obs !== exp[i]) begin n_bad++; $display("FAIL mixed[%0d]: got %h want %h", i, obs, exp[i]); end
            n_cmp++;
        end
    endtask

    task automatic test_errors();
        string s1 = "12+3";
        string s2 = "+5";
        string s3 = "4 +1";
        string s4 = "3+*";
        logic [25:0] e1 [4] = '{ {16'd1,1'b1,1'b0,8'd0}, {16'd1,1'b0,1'b1,8'd0}, {16'd1,1'b0,1'b1,8'd0}, {16'd1,1'b0,1'b1,8'd0} };
        logic [25:0] e2 [2] = '{ {16'd0,1'b0,1'b1,8'd0}, {16'd0,1'b0,1'b1,8'd0} };
        logic [25:0] e3 [4] = '{ {16'd4,1'b1,1'b0,8'd0}, {16'd4,1'b0,1'b1,8'd0}, {16'd4,1'b0,1'b1,8'd0}, {16'd4,1'b0,1'b1,8'd0} };
        logic [25:0] e4 [3] = '{ {16'd3,1'b1,1'b0,8'd0}, {16'd3,1'b0,1'b0,8'd1}, {16'd3,1'b0,1'b1,8'd1} };
        logic [25:0] seven = {16'd7,1'b1,1'b0,8'd0};

        do_clr();
        for (int i = 0; i < s1.len(); i++) begin
            send(s1[i]);
            if (obs !== e1[i]) begin n_bad++; $display("FAIL err_12[%0d]: got %h want %h", i, obs, e1[i]); end
            n_cmp++;
        end
        do_clr();
        if (obs !== 26'd0) begin n_bad++; $display("FAIL err_clr: got %h want %h", obs, 26'd0); end
        n_cmp++;

        for (int i = 0; i < s2.len(); i++) begin
            send(s2[i]);
            if (obs !== e2[i]) begin n_bad++; $display("FAIL err_lead_op[%0d]: got %h want %h", i, obs, e2[i]); end
            n_cmp++;
        end
        do_clr();
        send("7");
        if (obs !== seven) begin n_bad++; $display("FAIL err_recover1: got %h want %h", obs, seven); end
        n_cmp++;

        do_clr();
        for (int i = 0; i < s3.len(); i++) begin
            send(s3[i]);
            if (obs !== e3[i]) begin n_bad++; $display("FAIL err_space[%0d]: got %h want %h", i, obs, e3[i]); end
            n_cmp++;
        end
        do_clr();
        send("7");
        if (obs !== seven) begin n_bad++; $display("FAIL err_recover2: got %h want %h", obs, seven); end
        n_cmp++;

        do_clr();
        for (int i = 0; i < s4.len(); i++) begin
            send(s4[i]);
            if (obs !== e4[i]) begin n_bad++; $display("FAIL err_op_op[%0d]: got %h want %h", i, obs, e4[i]); end
            n_cmp++;
        end
    endtask

    task automatic test_gaps_wrap();
        // 9^5 = 59049 = 16'hE6A9; garbage on `in` while in_valid=0 must be ignored
        string s = "9*9*9*9*9";
        int gap [9] = '{0, 1, 3, 2, 0, 3, 1, 2, 0};
        logic [25:0] exp [9] = '{ {16'd9,1'b1,1'b0,8'd0}, {16'd9,1'b0,1'b0,8'd1}, {16'd81,1'b1,1'b0,8'd1},
                                  {16'd81,1'b0,1'b0,8'd2}, {16'd729,1'b1,1'b0,8'd2}, {16'd729,1'b0,1'b0,8'd3},
                                  {16'd6561,1'b1,1'b0,8'd3}, {16'd6561,1'b0,1'b0,8'd4}, {16'hE6A9,1'b1,1'b0,8'd4} };
        do_clr();
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            if (obs !== exp[i]) begin n_bad++; $display("FAIL wrap[%0d]: got %h want %h", i, obs, exp[i]); end
            n_cmp++;
            for (int g = 0; g < gap[i]; g++) begin
                in_ch = 8'h58;
                @(negedge clk);
                if (obs !== exp[i]) begin n_bad++; $display("FAIL gap[%0d.%0d]: got %h want %h", i, g, obs, exp[i]); end
                n_cmp++;
            end
        end
    endtask

    task automatic test_clr_mid();
        logic [25:0] six   = {16'd6,1'b1,1'b0,8'd0};
        logic [25:0] seven = {16'd7,1'b1,1'b0,8'd0};
        do_clr();
        send("5");
        send("*");
        // asynchronous: outputs clear before any rising edge
        clr = 1'b1;
        #2;
        if (obs !== 26'd0) begin n_bad++; $display("FAIL clr_async: got %h want %h", obs, 26'd0); end
        n_cmp++;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        if (obs !== 26'd0) begin n_bad++; $display("FAIL clr_hold: got %h want %h", obs, 26'd0); end
        n_cmp++;
        // mul_pend must have been cleared: '6' starts a fresh expression
        send("6");
        if (obs !== six) begin n_bad++; $display("FAIL clr_restart: got %h want %h", obs, six); end
        n_cmp++;

        // clr and a valid character on the same edge: character discarded
        in_ch = "8"; in_valid = 1'b1; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        if (obs !== 26'd0) begin n_bad++; $display("FAIL clr_vs_valid: got %h want %h", obs, 26'd0); end
        n_cmp++;
        send("7");
        if (obs !== seven) begin n_bad++; $display("FAIL clr_vs_valid_next: got %h want %h", obs, seven); end
        n_cmp++;
    endtask

    task automatic test_ops_saturate();
        logic [25:0] e254 = {16'd1,1'b1,1'b0,8'd254};
        logic [25:0] e255 = {16'd1,1'b1,1'b0,8'd255};
        logic [25:0] eop  = {16'd1,1'b0,1'b0,8'd255};
        logic [25:0] etwo = {16'd2,1'b1,1'b0,8'd255};
        do_clr();
        send("1");
        for (int i = 0; i < 255; i++) begin
            send("*");
            send("1");
            if (i == 253) begin
                if (obs !== e254) begin n_bad++; $display("FAIL sat_254: got %h want %h", obs, e254); end
                n_cmp++;
            end
        end
        if (obs !== e255) begin n_bad++; $display("FAIL sat_255: got %h want %h", obs, e255); end
        n_cmp++;
        send("*");
        if (obs !== eop) begin n_bad++; $display("FAIL sat_hold: got %h want %h", obs, eop); end
        n_cmp++;
        send("2");
        if (obs !== etwo) begin n_bad++; $display("FAIL sat_eval: got %h want %h", obs, etwo); end
        n_cmp++;
    endtask

    initial begin
        clr = 1'b1; in_valid = 1'b0; in_ch = 8'h00;
        @(negedge clk);
        test_reset();
        test_add();
        test_precedence();
        test_negative();
        test_mixed();
        test_errors();
        test_gaps_wrap();
        test_clr_mid();
        test_ops_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
